// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage feeding the decode controller. Owns the program
// counter, issues one outstanding request at a time to instruction memory over
// a req/gnt/rvalid handshake, and holds the fetched instruction (with its PC
// and pre-sliced opcode/funct3/funct7 fields) until the controller consumes
// it. Redirects from branch/jump resolution reload the PC; responses to
// requests made for a stale PC are absorbed and discarded.
//
// Parameters
//   XLEN        address/data width (only 32 is supported)
//   RESET_PC    PC loaded on reset, 4-byte aligned
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset
//   imem_req     out  request valid (only in the request state)
//   imem_addr    out  request address, equal to the current PC
//   imem_gnt     in   memory accepts the request this cycle
//   imem_rvalid  in   response valid (at most one per grant)
//   imem_rdata   in   response instruction word
//   redirect     in   one-cycle pulse: load redirect_pc
//   redirect_pc  in   branch/jump target
//   stall        in   downstream cannot consume the held instruction
//   instr_valid  out  instr, instr_pc and field outputs are valid
//   instr        out  fetched instruction (registered)
//   instr_pc     out  address of instr
//   opcode       out  instr[6:0]
//   funct3       out  instr[14:12]
//   funct7       out  instr[31:25]
//   misalign     out  sticky misaligned-redirect flag
//
// Build option
//   FETCH_MISALIGN_CHK_EN  when defined, a redirect whose target has non-zero
//                          low bits sets misalign and parks the unit in HALT
//                          until reset. When undefined, the low bits are
//                          cleared silently and misalign is tied low.
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int unsigned          XLEN     = 32,
   parameter logic [XLEN-1:0]      RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,

   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,

   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall,

   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [6:0]      opcode,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic            misalign
);

   localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

   // REQ   : request presented for pc
   // WAIT  : request granted for pc, waiting for its response
   // VALID : instruction held for the controller
   // DRAIN : a granted request for a stale pc is still outstanding
   // HALT  : parked after a misaligned redirect (only with the check enabled)
   typedef enum logic [2:0] {
      S_REQ,
      S_WAIT,
      S_VALID,
      S_DRAIN,
      S_HALT
   } state_t;

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] redirect_target;
   logic            redirect_bad;

   // Targets are always word aligned; the low two bits are either dropped or
   // trapped, depending on the build option.
   assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_CHK_EN
   assign redirect_bad = redirect && (redirect_pc[1:0] != 2'b00);
`else
   logic unused_redirect_lsb;

   assign redirect_bad        = 1'b0;
   assign unused_redirect_lsb = ^redirect_pc[1:0];
   assign misalign            = 1'b0;
`endif

   // The address is the PC itself, so it is stable for as long as the unit
   // sits in REQ, and a redirect in REQ shows the new target the next cycle.
   assign imem_addr = pc;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // NOTE: every register here is assigned with <= so that all of them see the
   // pre-edge values of state and pc, regardless of statement order below.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous; it is just the highest-priority branch of
      // the clocked logic and needs no separate sensitivity.
      if (rst) begin
         state       <= S_REQ;
         pc          <= RESET_PC;
         imem_req    <= 1'b1;
         instr_valid <= 1'b0;
         instr       <= INSTR_NOP;
         instr_pc    <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
         misalign    <= 1'b0;
`endif
      end else if (redirect_bad && (state != S_HALT)) begin
         // Misaligned target: park. Any outstanding response is absorbed in
         // HALT simply because HALT never looks at imem_rvalid.
         state       <= S_HALT;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
         misalign    <= 1'b1;
`endif
      end else begin
         case (state)
            S_REQ: begin
               if (redirect) begin
                  pc <= redirect_target;
                  // A grant in the redirect cycle was for the old pc; its
                  // response must be drained before the new request goes out.
                  if (imem_gnt) begin
                     state    <= S_DRAIN;
                     imem_req <= 1'b0;
                  end
               end else if (imem_gnt) begin
                  state    <= S_WAIT;
                  imem_req <= 1'b0;
               end
            end

            S_WAIT: begin
               if (redirect) begin
                  pc <= redirect_target;
                  if (imem_rvalid) begin
                     // Response for the old pc arrives with the redirect:
                     // drop it and request the target straight away.
                     state    <= S_REQ;
                     imem_req <= 1'b1;
                  end else begin
                     state    <= S_DRAIN;
                  end
               end else if (imem_rvalid) begin
                  instr       <= imem_rdata;
                  instr_pc    <= pc;
                  pc          <= pc + XLEN'(4);
                  state       <= S_VALID;
                  instr_valid <= 1'b1;
               end
            end

            S_VALID: begin
               // Redirect wins over stall: the held instruction is abandoned.
               if (redirect) begin
                  pc          <= redirect_target;
                  state       <= S_REQ;
                  imem_req    <= 1'b1;
                  instr_valid <= 1'b0;
               end else if (!stall) begin
                  state       <= S_REQ;
                  imem_req    <= 1'b1;
                  instr_valid <= 1'b0;
               end
            end

            S_DRAIN: begin
               if (redirect) begin
                  pc <= redirect_target;
               end
               if (imem_rvalid) begin
                  state    <= S_REQ;
                  imem_req <= 1'b1;
               end
            end

            S_HALT: begin
               state <= S_HALT;
            end

            default: begin
               state       <= S_REQ;
               imem_req    <= 1'b1;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A behavioural memory answers requests
// with a word derived from the address, and an instruction-stream model keeps
// the PC that the next presented instruction must carry: it advances by 4 when
// the held instruction is consumed and jumps to the aligned target on a
// redirect. Directed scenarios cover reset, zero-wait timing, stall, redirects
// in each phase, address wrap and the misaligned target; a randomized phase
// then mixes grant/response latency, stalls and redirects.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        misalign;

   fetch_unit #(
      .XLEN     (32),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .opcode      (opcode),
      .funct3      (funct3),
      .funct7      (funct7),
      .misalign    (misalign)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Memory contents: two fixed words at 0 and 4, a hash everywhere else.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0000) return 32'h0050_0093;
      if (a == 32'h0000_0004) return 32'h00A0_0113;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Values the main sequence wants applied at the next drive().
   logic        rst_drv;
   logic        stall_drv;
   logic        redirect_drv;
   logic [31:0] redirect_pc_drv;
   int          gnt_pct;
   int          dly_min;
   int          dly_max;

   // Memory model state.
   logic        outstanding;
   logic [31:0] out_addr;
   int          dly_cnt;
   int          rsp_cnt;

   // Instruction-stream model state.
   logic [31:0] exp_pc;
   logic        halted;
   int          present_cnt;

   // What happened at the previous edge.
   logic        prev_valid;
   logic        prev_stall;
   logic        prev_redirect;
   logic [31:0] prev_instr;
   logic [31:0] prev_pc;
   logic        prev_req_hold;
   logic [31:0] prev_addr;
   logic        prev_rvalid;

   // Sample the DUT mid-cycle and check it against the model.
   task automatic observe();
      logic [31:0] w;
      @(negedge clk);
      if (halted) begin
         check("halt_req", imem_req, 1'b0);
         check("halt_valid", instr_valid, 1'b0);
         check("halt_misalign", misalign, 1'b1);
      end else begin
         check("misalign_clear", misalign, 1'b0);
         if (outstanding) check("one_outstanding", imem_req, 1'b0);
         if (instr_valid) check("req_while_valid", imem_req, 1'b0);
         if (prev_req_hold) begin
            check("req_held", imem_req, 1'b1);
            check("addr_stable", imem_addr, prev_addr);
         end
         if (prev_redirect) begin
            check("valid_after_redirect", instr_valid, 1'b0);
         end else if (prev_valid && prev_stall) begin
            check("stall_valid", instr_valid, 1'b1);
            check("stall_instr", instr, prev_instr);
            check("stall_pc", instr_pc, prev_pc);
         end else if (prev_valid) begin
            check("valid_after_consume", instr_valid, 1'b0);
         end else if (instr_valid) begin
            present_cnt++;
            w = mem_word(exp_pc);
            check("valid_needs_rsp", prev_rvalid, 1'b1);
            check("instr_pc", instr_pc, exp_pc);
            check("instr", instr, w);
            check("opcode", opcode, w[6:0]);
            check("funct3", funct3, w[14:12]);
            check("funct7", funct7, w[31:25]);
         end
      end
   endtask

   // Apply inputs for the coming edge and advance the models across it.
   task automatic drive();
      logic g;
      logic rv;
      g  = imem_req && !outstanding && !rst_drv && ($urandom_range(99) < gnt_pct);
      rv = outstanding && (dly_cnt == 0) && !rst_drv;
      imem_gnt    = g;
      imem_rvalid = rv;
      imem_rdata  = rv ? mem_word(out_addr) : $urandom();
      rst         = rst_drv;
      stall       = stall_drv;
      redirect    = redirect_drv;
      redirect_pc = redirect_pc_drv;

      if (rst_drv) begin
         exp_pc        = RESET_PC;
         halted        = 1'b0;
         outstanding   = 1'b0;
         dly_cnt       = 0;
         prev_valid    = 1'b0;
         prev_stall    = 1'b0;
         prev_redirect = 1'b0;
         prev_req_hold = 1'b0;
         prev_rvalid   = 1'b0;
      end else begin
         if (rv) rsp_cnt++;
         if (!halted) begin
            if (redirect_drv) begin
`ifdef FETCH_MISALIGN_CHK_EN
               if (redirect_pc_drv[1:0] != 2'b00) halted = 1'b1;
               else exp_pc = {redirect_pc_drv[31:2], 2'b00};
`else
               exp_pc = {redirect_pc_drv[31:2], 2'b00};
`endif
            end else if (instr_valid && !stall_drv) begin
               exp_pc = instr_pc + 32'd4;
            end
         end
         prev_valid    = instr_valid;
         prev_stall    = stall_drv;
         prev_redirect = redirect_drv;
         prev_instr    = instr;
         prev_pc       = instr_pc;
         prev_req_hold = imem_req && !g && !redirect_drv;
         prev_addr     = imem_addr;
         prev_rvalid   = rv;
         if (g) begin
            outstanding = 1'b1;
            out_addr    = imem_addr;
            dly_cnt     = $urandom_range(dly_max, dly_min);
         end else if (rv) begin
            outstanding = 1'b0;
         end else if (outstanding && dly_cnt > 0) begin
            dly_cnt--;
         end
      end
      redirect_drv = 1'b0;
   endtask

   // Both helpers start and end in the observed (not yet driven) state.
   task automatic run_until_valid(input string tag, input int budget);
      int n = 0;
      while (!instr_valid && n < budget) begin
         drive();
         observe();
         n++;
      end
      check(tag, instr_valid, 1'b1);
   endtask

   task automatic run_until_req(input string tag, input int budget);
      int n = 0;
      while (!imem_req && n < budget) begin
         drive();
         observe();
         n++;
      end
      check(tag, imem_req, 1'b1);
   endtask

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      t = 32'($urandom_range(32'h3FF));
      if ($urandom_range(7) == 0) t = t | 32'hFFFF_FC00;
`ifdef FETCH_MISALIGN_CHK_EN
      t[1:0] = 2'b00;
`endif
      return t;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] addrs[$];
      logic [31:0] held_pc;
      logic [31:0] held_instr;
      int          rsp_base;
      int          base;
      int          n;

      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      rst_drv = 1'b1; stall_drv = 1'b0; redirect_drv = 1'b0; redirect_pc_drv = '0;
      gnt_pct = 100; dly_min = 0; dly_max = 0;
      outstanding = 1'b0; out_addr = '0; dly_cnt = 0; rsp_cnt = 0;
      exp_pc = RESET_PC; halted = 1'b0; present_cnt = 0;
      prev_valid = 1'b0; prev_stall = 1'b0; prev_redirect = 1'b0; prev_instr = '0;
      prev_pc = '0; prev_req_hold = 1'b0; prev_addr = '0; prev_rvalid = 1'b0;

      // Reset, then zero-wait memory for eight cycles.
      repeat (2) begin
         observe();
         drive();
      end
      rst_drv = 1'b0;
      for (int c = 0; c < 8; c++) begin
         observe();
         if (c == 0) begin
            check("rst_req", imem_req, 1'b1);
            check("rst_addr", imem_addr, RESET_PC);
            check("rst_valid", instr_valid, 1'b0);
            check("rst_instr", instr, INSTR_NOP);
            check("rst_instr_pc", instr_pc, 32'h0);
            check("rst_misalign", misalign, 1'b0);
         end
         if (imem_req) addrs.push_back(imem_addr);
         check($sformatf("zw_valid_c%0d", c), instr_valid, (c == 2 || c == 5));
         if (c == 2) begin
            check("zw_pc0", instr_pc, 32'h0);
            check("zw_instr0", instr, 32'h0050_0093);
            check("zw_opcode0", opcode, 7'h13);
            check("zw_funct3_0", funct3, 3'h0);
         end
         if (c == 5) begin
            check("zw_pc1", instr_pc, 32'h4);
            check("zw_instr1", instr, 32'h00A0_0113);
            check("zw_opcode1", opcode, 7'h13);
            check("zw_funct3_1", funct3, 3'h0);
         end
         drive();
      end
      check("zw_req_count", addrs.size(), 3);
      if (addrs.size() >= 3) begin
         check("zw_addr0", addrs[0], 32'h0);
         check("zw_addr1", addrs[1], 32'h4);
         check("zw_addr2", addrs[2], 32'h8);
      end

      // Stall for four cycles while an instruction is held.
      observe();
      run_until_valid("stall_setup", 20);
      held_pc    = instr_pc;
      held_instr = instr;
      for (int k = 0; k < 4; k++) begin
         stall_drv = 1'b1;
         drive();
         observe();
         check("stall_hold_valid", instr_valid, 1'b1);
         check("stall_hold_pc", instr_pc, held_pc);
         check("stall_hold_instr", instr, held_instr);
         check("stall_no_req", imem_req, 1'b0);
      end
      stall_drv = 1'b0;
      drive();
      observe();
      run_until_req("stall_next_req", 20);
      check("stall_next_addr", imem_addr, held_pc + 32'd4);

      // Redirect while waiting; the stale response arrives two cycles later.
      dly_min = 2; dly_max = 2;
      drive();
      observe();
      check("wait_state_no_req", imem_req, 1'b0);
      redirect_drv = 1'b1; redirect_pc_drv = 32'h0000_0100;
      drive();
      observe();
      n = 0;
      while (!imem_req && n < 20) begin
         check("drain_no_valid", instr_valid, 1'b0);
         drive();
         observe();
         n++;
      end
      check("redir_wait_req", imem_req, 1'b1);
      check("redir_wait_addr", imem_addr, 32'h0000_0100);

      // Redirect in REQ with no grant: the address moves on the next cycle.
      gnt_pct = 0;
      redirect_drv = 1'b1; redirect_pc_drv = 32'h0000_0200;
      drive();
      observe();
      check("redir_req_req", imem_req, 1'b1);
      check("redir_req_addr", imem_addr, 32'h0000_0200);
      rsp_base = rsp_cnt;
      gnt_pct = 100; dly_min = 0; dly_max = 1;
      run_until_valid("redir_req_valid", 20);
      check("redir_req_pc", instr_pc, 32'h0000_0200);
      check("redir_req_one_rsp", rsp_cnt - rsp_base, 1);

      // Fetch from the top word; the next request wraps to zero.
      redirect_drv = 1'b1; redirect_pc_drv = 32'hFFFF_FFFC;
      drive();
      observe();
      run_until_valid("wrap_valid", 20);
      check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
      drive();
      observe();
      run_until_req("wrap_req", 20);
      check("wrap_addr", imem_addr, 32'h0);

      // Misaligned target, granted in the same cycle.
      redirect_drv = 1'b1; redirect_pc_drv = 32'h0000_0102;
      drive();
`ifdef FETCH_MISALIGN_CHK_EN
      for (int k = 0; k < 10; k++) begin
         observe();
         check("mis_flag", misalign, 1'b1);
         check("mis_no_req", imem_req, 1'b0);
         redirect_drv = (k == 4);
         redirect_pc_drv = 32'h0000_0300;
         drive();
      end
      rst_drv = 1'b1;
      observe();
      drive();
      rst_drv = 1'b0;
      observe();
      check("mis_rst_flag", misalign, 1'b0);
      check("mis_rst_req", imem_req, 1'b1);
      check("mis_rst_addr", imem_addr, RESET_PC);
`else
      observe();
      run_until_req("mis_req", 20);
      check("mis_addr", imem_addr, 32'h0000_0100);
      run_until_valid("mis_valid", 20);
      check("mis_pc", instr_pc, 32'h0000_0100);
      check("mis_flag", misalign, 1'b0);
`endif

      // Randomized traffic.
      gnt_pct = 60; dly_min = 0; dly_max = 3;
      base = present_cnt;
      for (int i = 0; i < 3000; i++) begin
         stall_drv = ($urandom_range(99) < 30);
         if ($urandom_range(99) < 4) begin
            redirect_drv    = 1'b1;
            redirect_pc_drv = rand_target();
         end
         drive();
         observe();
      end
      check("random_progress", (present_cnt - base) >= 100, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
